// File: rtl/spram_bist_pkg.sv
// Shared definitions for the single-port RAM BIST controller:
// pattern codes, FSM state encoding and the address-to-data pattern function.
package spram_bist_pkg;

    typedef enum logic [1:0] {
        PAT_DESCEND     = 2'd0,
        PAT_ADDR        = 2'd1,
        PAT_CHECKER     = 2'd2,
        PAT_INV_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } bist_state_e;

    localparam logic [63:0] CHECKER_EVEN = {32{2'b10}};
    localparam logic [63:0] CHECKER_ODD  = {32{2'b01}};

    // Produces a 64-bit word; callers keep the low DATA_WIDTH bits, which turns
    // ~addr into all-ones minus addr modulo 2**DATA_WIDTH.
    function automatic logic [63:0] pattern_word(input logic [63:0] addr, input pattern_e pat);
        logic [63:0] word;
        case (pat)
            PAT_DESCEND:     word = ~addr;
            PAT_ADDR:        word = addr;
            PAT_CHECKER:     word = addr[0] ? CHECKER_ODD : CHECKER_EVEN;
            PAT_INV_CHECKER: word = addr[0] ? CHECKER_EVEN : CHECKER_ODD;
            default:         word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/spram_bist_chk.sv
// Read-data checker: delays valid/expected/address by the RAM read latency,
// compares against returned data, counts mismatches and captures the first one.
module spram_bist_chk
    import spram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     clear,
    input  logic                     rd_valid,
    input  logic [DATA_WIDTH-1:0]    exp_data,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     first_err_valid,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    localparam int LAST = RD_LATENCY - 1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    logic                  vld_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] exp_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] adr_q [RD_LATENCY];
    logic                  mismatch;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_valid;
            exp_q[0] <= exp_data;
            adr_q[0] <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    assign mismatch = vld_q[LAST] && (ram_rd_data != exp_q[LAST]);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (clear) begin
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (mismatch) begin
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= adr_q[LAST];
            end
        end
    end

endmodule

// File: rtl/spram_bist_ctrl.sv
// BIST controller for single-port RAMs: one full write pass of a selectable
// pattern, one full read pass, and a pass/fail verdict from the checker.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; results of the last test held
// WRITE    | writing pattern(addr) to addr 0..depth-1
// GAP      | one dead cycle between passes, address parked at 0
// READ     | reading addr 0..depth-1, expected data fed to checker
// DRAIN    | RD_LATENCY cycles so the final read is compared
// DONE     | one-cycle done pulse, pass becomes valid
module spram_bist_ctrl
    import spram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 16,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     tb_rst,
    input  logic                     start,
    input  logic [1:0]               pattern,
    output logic [ADDR_WIDTH-1:0]    ram_addr,
    output logic                     ram_wr_en,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     first_err_valid,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    localparam int DRAIN_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DRAIN_W-1:0]    drain_q;
    pattern_e              pat_q;
    logic                  pass_hold_q;
    logic                  start_acc;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] pat_data;

    assign start_acc = start && (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_WRITE;
            ST_WRITE: if (addr_q == ADDR_LAST) state_d = ST_GAP;
            ST_GAP:   state_d = ST_READ;
            ST_READ:  if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        ram_wr_en   = (state_q == ST_WRITE);
        rd_valid    = (state_q == ST_READ);
        pat_data    = DATA_WIDTH'(pattern_word(64'(addr_q), pat_q));
        ram_wr_data = ram_wr_en ? pat_data : '0;
        ram_addr    = addr_q;
        pass        = ((state_q == ST_DONE) || pass_hold_q) && (err_cnt == '0);
    end

    // Address wraps to 0 on its own after the last location of each pass.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            addr_q <= '0;
        end else if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
            addr_q <= addr_q + 1'b1;
        end else begin
            addr_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            drain_q <= DRAIN_LOAD;
        end else if (state_q == ST_DRAIN) begin
            drain_q <= drain_q - 1'b1;
        end else begin
            drain_q <= DRAIN_LOAD;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            pat_q       <= PAT_DESCEND;
            pass_hold_q <= 1'b0;
        end else if (start_acc) begin
            pat_q       <= pattern_e'(pattern);
            pass_hold_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            pass_hold_q <= 1'b1;
        end
    end

    spram_bist_chk #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .RD_LATENCY    (RD_LATENCY),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_chk (
        .clk             (clk),
        .tb_rst          (tb_rst),
        .clear           (start_acc),
        .rd_valid        (rd_valid),
        .exp_data        (pat_data),
        .rd_addr         (addr_q),
        .ram_rd_data     (ram_rd_data),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
    );

endmodule

// File: tb/tb_spram_bist_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 2), each driving a
// behavioural RAM with per-address bit-flip and stuck-at-zero fault injection.
module tb_spram_bist_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic tb_rst;
    logic start1, start2;
    logic [1:0] pattern;

    logic [AW-1:0] a1, a2, fea1, fea2;
    logic          we1, we2, busy1, busy2, done1, done2, pass1, pass2, fev1, fev2;
    logic [DW-1:0] wd1, wd2, rd1, rd2;
    logic [2:0]    err1, err2;

    always #5 clk = ~clk;

    spram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut1 (
        .clk(clk), .tb_rst(tb_rst), .start(start1), .pattern(pattern),
        .ram_addr(a1), .ram_wr_en(we1), .ram_wr_data(wd1), .ram_rd_data(rd1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_addr(fea1));

    spram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) dut2 (
        .clk(clk), .tb_rst(tb_rst), .start(start2), .pattern(pattern),
        .ram_addr(a2), .ram_wr_en(we2), .ram_wr_data(wd2), .ram_rd_data(rd2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_valid(fev2), .first_err_addr(fea2));

    // RAM models; flip[] corrupts read data, stuck forces the output to zero.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    logic [DW-1:0] flip [DEPTH];
    logic          stuck;
    logic [DW-1:0] r1q, r2a, r2b;

    always @(posedge clk) begin
        if (we1) mem1[a1] <= wd1;
        r1q <= mem1[a1] ^ flip[a1];
        if (we2) mem2[a2] <= wd2;
        r2a <= mem2[a2] ^ flip[a2];
        r2b <= r2a;
    end
    assign rd1 = stuck ? '0 : r1q;
    assign rd2 = stuck ? '0 : r2b;

    int sel;
    logic [AW-1:0] s_addr, s_fea;
    logic          s_we, s_busy, s_done, s_pass, s_fev;
    logic [DW-1:0] s_wd;
    logic [2:0]    s_err;
    always_comb begin
        s_addr = (sel == 2) ? a2 : a1;
        s_we   = (sel == 2) ? we2 : we1;
        s_wd   = (sel == 2) ? wd2 : wd1;
        s_busy = (sel == 2) ? busy2 : busy1;
        s_done = (sel == 2) ? done2 : done1;
        s_pass = (sel == 2) ? pass2 : pass1;
        s_err  = (sel == 2) ? err2 : err1;
        s_fev  = (sel == 2) ? fev2 : fev1;
        s_fea  = (sel == 2) ? fea2 : fea1;
    end

    int checks = 0;
    int errors = 0;

    int r_busy, r_done, r_wr_cnt, r_wr_bad, r_timeout, r_extra;
    int r_err, r_fev, r_fea, r_pass_done, r_pass_after;
    logic [DW-1:0] r_wr0, r_wrlast;
    int e_err, e_first, e_any;

    function automatic logic [DW-1:0] ref_pat(input int a, input int p);
        case (p)
            0:       return DW'(65535 - a);
            1:       return DW'(a);
            2:       return (a % 2 == 0) ? 16'hAAAA : 16'h5555;
            default: return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
        endcase
    endfunction

    // Expected verdict: which addresses will read back differently from what was written.
    task automatic ref_result(input int p);
        int n;
        logic [DW-1:0] rd;
        n = 0;
        e_first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd = stuck ? '0 : (ref_pat(a, p) ^ flip[a]);
            if (rd != ref_pat(a, p)) begin
                if (n == 0) e_first = a;
                n++;
            end
        end
        e_any = (n > 0) ? 1 : 0;
        e_err = (n > 7) ? 7 : n;
    endtask

    task automatic drive_start(input logic v);
        start1 = (sel == 1) ? v : 1'b0;
        start2 = (sel == 2) ? v : 1'b0;
    endtask

    task automatic clear_faults();
        stuck = 1'b0;
        for (int a = 0; a < DEPTH; a++) flip[a] = '0;
    endtask

    task automatic run_test(input int which, input int pat, input int extra_at, input bit start_on_done);
        int cyc, widx;
        bit seen;
        sel = which;
        pattern = pat[1:0];
        r_busy = 0; r_done = 0; r_wr_cnt = 0; r_wr_bad = 0; r_timeout = 0; r_extra = 0;
        r_err = -1; r_fev = -1; r_fea = -1; r_pass_done = -1;
        r_wr0 = 'x; r_wrlast = 'x;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        cyc = 0; widx = 0; seen = 0;
        while (1) begin
            if (s_busy) begin seen = 1; r_busy++; end
            if (seen && !s_busy) break;
            if (s_we) begin
                if (int'(s_addr) != widx || s_wd !== ref_pat(int'(s_addr), pat)) r_wr_bad++;
                if (s_addr == 0) r_wr0 = s_wd;
                if (s_addr == AW'(DEPTH - 1)) r_wrlast = s_wd;
                widx++;
                r_wr_cnt++;
            end
            if (s_done) begin
                r_done++;
                r_err = int'(s_err); r_fev = int'(s_fev); r_fea = int'(s_fea); r_pass_done = int'(s_pass);
            end
            if (cyc == extra_at || (start_on_done && s_done)) drive_start(1'b1);
            else drive_start(1'b0);
            if (cyc > 4000) begin r_timeout = 1; break; end
            @(negedge clk); cyc++;
        end
        drive_start(1'b0);
        r_pass_after = int'(s_pass);
        repeat (5) begin
            @(negedge clk);
            if (s_busy || s_done) r_extra++;
        end
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a1, we1, wd1, busy1, done1, pass1, err1, fev1, fea1} !== '0) begin
            errors++; $display("FAIL reset_dut1 outputs=%h required=0", {a1, we1, wd1, busy1, done1, pass1, err1, fev1, fea1});
        end
        checks++;
        if ({a2, we2, wd2, busy2, done2, pass2, err2, fev2, fea2} !== '0) begin
            errors++; $display("FAIL reset_dut2 outputs=%h required=0", {a2, we2, wd2, busy2, done2, pass2, err2, fev2, fea2});
        end
        tb_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_descend_ideal();
        clear_faults();
        run_test(1, 0, -1, 0);
        checks++; if (r_timeout != 0) begin errors++; $display("FAIL descend_timeout got=%0d want=0", r_timeout); end
        checks++; if (r_wr0 !== 16'hFFFF) begin errors++; $display("FAIL descend_wr0 got=%h want=ffff", r_wr0); end
        checks++; if (r_wrlast !== 16'hFE00) begin errors++; $display("FAIL descend_wrlast got=%h want=fe00", r_wrlast); end
        checks++; if (r_wr_bad != 0 || r_wr_cnt != DEPTH) begin errors++; $display("FAIL descend_wrstream bad=%0d cnt=%0d want 0/%0d", r_wr_bad, r_wr_cnt, DEPTH); end
        checks++; if (r_busy != 1027) begin errors++; $display("FAIL descend_busy got=%0d want=1027", r_busy); end
        checks++; if (r_done != 1) begin errors++; $display("FAIL descend_done got=%0d want=1", r_done); end
        checks++; if (r_pass_done != 1 || r_err != 0 || r_fev != 0) begin errors++; $display("FAIL descend_verdict pass=%0d err=%0d fev=%0d want 1/0/0", r_pass_done, r_err, r_fev); end
        checks++; if (r_pass_after != 1) begin errors++; $display("FAIL descend_pass_hold got=%0d want=1", r_pass_after); end
    endtask

    task automatic test_flip_addr5();
        clear_faults();
        flip[5] = 16'h0001;
        run_test(1, 1, -1, 0);
        checks++; if (r_err != 1) begin errors++; $display("FAIL flip5_err got=%0d want=1", r_err); end
        checks++; if (r_fev != 1 || r_fea != 5) begin errors++; $display("FAIL flip5_first fev=%0d addr=%0d want 1/5", r_fev, r_fea); end
        checks++; if (r_pass_done != 0 || r_pass_after != 0) begin errors++; $display("FAIL flip5_pass got=%0d/%0d want=0", r_pass_done, r_pass_after); end
        checks++; if (r_busy != 1027 || r_done != 1) begin errors++; $display("FAIL flip5_timing busy=%0d done=%0d want 1027/1", r_busy, r_done); end
    endtask

    task automatic test_stuck_zero();
        clear_faults();
        stuck = 1'b1;
        run_test(1, 2, -1, 0);
        checks++; if (r_err != 7) begin errors++; $display("FAIL stuck_err got=%0d want=7", r_err); end
        checks++; if (r_fev != 1 || r_fea != 0) begin errors++; $display("FAIL stuck_first fev=%0d addr=%0d want 1/0", r_fev, r_fea); end
        checks++; if (r_pass_done != 0) begin errors++; $display("FAIL stuck_pass got=%0d want=0", r_pass_done); end
        clear_faults();
    endtask

    task automatic test_latency2();
        clear_faults();
        run_test(2, 3, -1, 0);
        checks++; if (r_busy != 1028) begin errors++; $display("FAIL lat2_busy got=%0d want=1028", r_busy); end
        checks++; if (r_pass_done != 1 || r_err != 0 || r_fev != 0) begin errors++; $display("FAIL lat2_verdict pass=%0d err=%0d fev=%0d want 1/0/0", r_pass_done, r_err, r_fev); end
        checks++; if (r_wr_bad != 0 || r_wr_cnt != DEPTH) begin errors++; $display("FAIL lat2_wrstream bad=%0d cnt=%0d", r_wr_bad, r_wr_cnt); end
    endtask

    task automatic test_random();
        int which, pat, nflip;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            which = $urandom_range(1, 2);
            pat   = $urandom_range(0, 3);
            nflip = $urandom_range(0, 10);
            for (int k = 0; k < nflip; k++) flip[$urandom_range(0, DEPTH - 1)] = DW'($urandom_range(1, 65535));
            ref_result(pat);
            run_test(which, pat, -1, 0);
            checks++; if (r_err != e_err) begin errors++; $display("FAIL rand%0d_err got=%0d want=%0d", it, r_err, e_err); end
            checks++; if (r_fev != e_any || r_fea != e_first) begin errors++; $display("FAIL rand%0d_first fev=%0d addr=%0d want %0d/%0d", it, r_fev, r_fea, e_any, e_first); end
            checks++; if (r_pass_done != 1 - e_any) begin errors++; $display("FAIL rand%0d_pass got=%0d want=%0d", it, r_pass_done, 1 - e_any); end
            checks++; if (r_busy != 1026 + which || r_wr_bad != 0) begin errors++; $display("FAIL rand%0d_busy got=%0d wrbad=%0d want %0d/0", it, r_busy, r_wr_bad, 1026 + which); end
        end
        clear_faults();
    endtask

    task automatic test_reset_mid_write();
        int n;
        bit hit;
        clear_faults();
        sel = 1;
        pattern = 2'd1;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        hit = 0;
        for (n = 0; n < 300 && !hit; n++) begin
            if (s_we && s_addr == 100) hit = 1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrst_reach_addr100 got=timeout want=reached"); end
        tb_rst = 1'b1;
        #1;
        checks++;
        if ({a1, we1, wd1, busy1, done1, pass1, err1, fev1, fea1} !== '0) begin
            errors++; $display("FAIL midrst_outputs got=%h want=0", {a1, we1, wd1, busy1, done1, pass1, err1, fev1, fea1});
        end
        @(negedge clk);
        tb_rst = 1'b0;
        run_test(1, 1, -1, 0);
        checks++; if (r_busy != 1027 || r_pass_done != 1 || r_err != 0) begin errors++; $display("FAIL midrst_rerun busy=%0d pass=%0d err=%0d want 1027/1/0", r_busy, r_pass_done, r_err); end
    endtask

    task automatic test_back_to_back();
        clear_faults();
        run_test(1, 0, 700, 0);
        checks++; if (r_done != 1 || r_busy != 1027 || r_extra != 0) begin errors++; $display("FAIL b2b_read_start done=%0d busy=%0d extra=%0d want 1/1027/0", r_done, r_busy, r_extra); end
        checks++; if (r_pass_done != 1 || r_err != 0) begin errors++; $display("FAIL b2b_read_verdict pass=%0d err=%0d want 1/0", r_pass_done, r_err); end
        flip[9] = 16'h8000;
        run_test(1, 2, 600, 1);
        checks++; if (r_done != 1 || r_extra != 0) begin errors++; $display("FAIL b2b_done_start done=%0d extra=%0d want 1/0", r_done, r_extra); end
        checks++; if (r_err != 1 || r_fea != 9 || r_pass_after != 0) begin errors++; $display("FAIL b2b_counts err=%0d addr=%0d pass=%0d want 1/9/0", r_err, r_fea, r_pass_after); end
        clear_faults();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1;
        start1 = 1'b0;
        start2 = 1'b0;
        pattern = 2'd0;
        clear_faults();
        test_reset();
        test_descend_ideal();
        test_flip_addr5();
        test_stuck_zero();
        test_latency2();
        test_random();
        test_reset_mid_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
